ctr_buffer: RTL
===============

# ctr_buffer

Parametrised circular Control Transfer Records buffer. It sits in the CTR subsystem between the record emitter and the CSR regfile. It accepts up to NrCommitPorts formatted records per cycle, stores them in commit order in a ring of selectable depth, and serves indexed one-cycle-latency reads for the CTR entry CSRs. It adds behaviour the single-record emitter path lacks: runtime depth selection, freeze, clear, write-pointer CSR access and multi-record-per-cycle packing.

## Interface
- CVA6Cfg, config_pkg::cva6_cfg_empty: core configuration; NrPorts = CVA6Cfg.NrCommitPorts.
- MaxDepth, 16: physical entries; power of two in 16..256.
- clk_i  in  1  core clock.
- rstn_i  in  1  asynchronous active-low reset.
- source_i  in  NrPorts x riscv::ctrsource_rv_t  record source, bit 0 = V.
- target_i  in  NrPorts x riscv::ctrtarget_rv_t  record target.
- data_i  in  NrPorts x riscv::ctrdata_rv_t  record data.
- valid_i  in  NrPorts  per-port record valid; gaps allowed.
- freeze_i  in  1  sctrstatus.FROZEN; drop all records while high.
- clear_i  in  1  sctrclr pulse.
- depth_sel_i  in  3  sctrdepth encoding: effective depth = 16 << depth_sel_i, capped at MaxDepth.
- wrptr_we_i  in  1  CSR write of WRPTR.
- wrptr_i  in  8  WRPTR write value.
- wrptr_o  out  8  current WRPTR, zero-extended.
- rd_req_i  in  1  entry read request.
- rd_idx_i  in  8  logical index; 0 = most recent record.
- rd_valid_o  out  1  read response valid.
- rd_source_o / rd_target_o / rd_data_o  out  record types  read response.

## Operation
- EffDepth = min(16 << depth_sel_i, MaxDepth); Mask = EffDepth-1.
- Per cycle, priority clear > wrptr write > record insert:
  - clear_i: every entry zeroed, wrptr := 0; records and wrptr_we that cycle are ignored.
  - wrptr_we_i: wrptr := wrptr_i & Mask; records that cycle are dropped.
  - Otherwise, if freeze_i = 0: let k = popcount(valid_i). Valid records are packed in ascending port order into slots (wrptr + j) & Mask, j = 0..k-1, and wrptr := (wrptr + k) & Mask.
- If k > EffDepth (NrPorts > 16 only), the later records win. With legal configurations k <= NrPorts <= EffDepth, so this case does not occur.
- Read mapping: physical = (wrptr - 1 - rd_idx_i) & Mask, computed on the cycle-N wrptr. If rd_idx_i >= EffDepth, the response is all-zero.
- Depth change: wrptr is re-masked to the new Mask on the next cycle. Entries are not cleared. Physical entries above EffDepth keep their content and become reachable again if the depth grows.
- Never-written or cleared entries read as zero, so V = 0.

## Timing
- Reset: all entries, wrptr, rd_valid_o and all rd_*_o are zero. wrptr_o = 0.
- Insert: records presented in cycle N are stored at the edge ending N. wrptr_o reflects the new value in N+1.
- Read: rd_req_i in cycle N gives rd_valid_o = 1 and data in N+1. Data is taken from storage as it was during N, i.e. before the cycle-N insert.
- rd_valid_o is high for exactly one cycle per request. Back-to-back requests are accepted every cycle. rd_*_o hold their value when rd_valid_o = 0.
- Read and insert in the same cycle are both serviced, with no stall.
- Reset asserted mid-operation clears everything asynchronously. A pending read response is lost.

## Structure
- riscv package (alongside ctrsource/target/data_rv_t):
  - CTR_MAX_DEPTH = 256.
  - ctr_depth_e encoding, 0..4 → 16..256.
  - ctr_entry_t struct {source, target, data}.
- Sub-module ctr_slot_alloc: combinational prefix-popcount over valid_i. It outputs a per-port slot offset and total k.
- Storage is a flop array of ctr_entry_t with one write per port and one read port.
- ctr_unit instantiates ctr_buffer after ctr_emitter.

## Test plan
- Reset then read idx 0 → rd_valid_o = 1 next cycle, all data 0, wrptr_o = 0.
- MaxDepth = 16, NrPorts = 2, depth_sel = 0, valid_i = 2'b11 for 9 cycles with sources 2,4,…,36 → wrptr_o = 2. idx 0 returns 36, idx 1 returns 34, idx 15 returns 6.
- valid_i = 2'b10 with source[1] = 0x100 → stored in slot wrptr, wrptr advances by 1. idx 0 returns 0x100.
- freeze_i = 1 plus valid_i = 2'b11 → wrptr unchanged, contents unchanged. Then clear_i together with wrptr_we_i = 5 → wrptr_o = 0 and every index reads 0.
- wrptr_we_i = 0x23 with depth_sel = 0 → wrptr_o = 3. Same-cycle valid records are dropped. Read idx 20 → zero response.
- Same-cycle rd_req idx 0 and insert of source 0x40 → response shows the previous newest record. A read on the next cycle returns 0x40.

Source files
------------

// File: rtl/ctr_buffer_pkg.sv
// Shared types and helpers for the circular Control Transfer Records buffer.
// Record types mirror the riscv CTR CSR formats (source bit 0 = V).
package ctr_buffer_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned CTR_MAX_DEPTH = 256;

  typedef logic [XLEN-1:0] ctrsource_rv_t;
  typedef logic [XLEN-1:0] ctrtarget_rv_t;
  typedef logic [31:0]     ctrdata_rv_t;

  typedef enum logic [2:0] {
    CTR_DEPTH_16  = 3'd0,
    CTR_DEPTH_32  = 3'd1,
    CTR_DEPTH_64  = 3'd2,
    CTR_DEPTH_128 = 3'd3,
    CTR_DEPTH_256 = 3'd4
  } ctr_depth_e;

  typedef struct packed {
    ctrsource_rv_t source;
    ctrtarget_rv_t target;
    ctrdata_rv_t   data;
  } ctr_entry_t;

  // Index mask for the effective depth; reserved encodings fall back to the largest ring.
  function automatic logic [7:0] ctr_mask(input logic [2:0] depth_sel,
                                          input int unsigned max_depth);
    int unsigned depth;
    case (ctr_depth_e'(depth_sel))
      CTR_DEPTH_16:  depth = 16;
      CTR_DEPTH_32:  depth = 32;
      CTR_DEPTH_64:  depth = 64;
      CTR_DEPTH_128: depth = 128;
      CTR_DEPTH_256: depth = 256;
      default:       depth = CTR_MAX_DEPTH;
    endcase
    if (depth > max_depth) depth = max_depth;
    return 8'(depth - 1);
  endfunction

endpackage

// File: rtl/ctr_buffer_slot_alloc.sv
// Prefix popcount over the per-port valid bits: each valid record gets its
// offset from the write pointer, and count is the total number of records.
module ctr_slot_alloc #(
  parameter int unsigned NrPorts = 2
) (
  input  logic [NrPorts-1:0]      valid,
  output logic [NrPorts-1:0][7:0] offset,
  output logic [7:0]              count
);

  logic [7:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int unsigned p = 0; p < NrPorts; p++) begin
      offset[p] = acc;
      acc       = acc + 8'(valid[p]);
    end
    count = acc;
  end

endmodule

// File: rtl/ctr_buffer.sv
// Circular CTR record buffer: packs up to NrPorts records per cycle in commit
// order, with runtime depth, freeze, clear, WRPTR access and 1-cycle reads.
module ctr_buffer
  import ctr_buffer_pkg::*;
#(
  parameter int unsigned NrPorts  = 2,
  parameter int unsigned MaxDepth = 16
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  ctrsource_rv_t [NrPorts-1:0] source_i,
  input  ctrtarget_rv_t [NrPorts-1:0] target_i,
  input  ctrdata_rv_t   [NrPorts-1:0] data_i,
  input  logic          [NrPorts-1:0] valid_i,
  input  logic                        freeze_i,
  input  logic                        clear_i,
  input  logic          [2:0]         depth_sel_i,
  input  logic                        wrptr_we_i,
  input  logic          [7:0]         wrptr_i,
  output logic          [7:0]         wrptr_o,
  input  logic                        rd_req_i,
  input  logic          [7:0]         rd_idx_i,
  output logic                        rd_valid_o,
  output ctrsource_rv_t               rd_source_o,
  output ctrtarget_rv_t               rd_target_o,
  output ctrdata_rv_t                 rd_data_o
);

  localparam int unsigned AW = $clog2(MaxDepth);

  logic [7:0]              mask;
  logic [7:0]              wrptr;
  logic [7:0]              wrptr_next;
  logic [7:0]              count;
  logic [NrPorts-1:0][7:0] offset;
  logic [AW-1:0]           slot [NrPorts];
  logic [AW-1:0]           rd_phys;
  logic                    rd_oob;
  logic                    insert_en;

  ctr_entry_t mem [MaxDepth];
  ctr_entry_t rd_entry;
  logic       rd_valid;

  assign mask      = ctr_mask(depth_sel_i, MaxDepth);
  assign insert_en = !clear_i && !wrptr_we_i && !freeze_i;

  ctr_slot_alloc #(
    .NrPorts(NrPorts)
  ) u_slot_alloc (
    .valid (valid_i),
    .offset(offset),
    .count (count)
  );

  // Masking with the current depth every cycle also re-wraps wrptr after a depth shrink.
  always_comb begin
    for (int unsigned p = 0; p < NrPorts; p++) begin
      slot[p] = AW'((wrptr + offset[p]) & mask);
    end
    rd_phys = AW'((wrptr - 8'd1 - rd_idx_i) & mask);
    rd_oob  = rd_idx_i > mask;

    if (clear_i) begin
      wrptr_next = '0;
    end else if (wrptr_we_i) begin
      wrptr_next = wrptr_i & mask;
    end else if (freeze_i) begin
      wrptr_next = wrptr & mask;
    end else begin
      wrptr_next = (wrptr + count) & mask;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wrptr <= '0;
    end else begin
      wrptr <= wrptr_next;
    end
  end

  // Later ports are written last, so they win if two records ever alias a slot.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < MaxDepth; i++) begin
        mem[i] <= '0;
      end
    end else if (clear_i) begin
      for (int unsigned i = 0; i < MaxDepth; i++) begin
        mem[i] <= '0;
      end
    end else if (insert_en) begin
      for (int unsigned p = 0; p < NrPorts; p++) begin
        if (valid_i[p]) begin
          mem[slot[p]] <= '{source: source_i[p], target: target_i[p], data: data_i[p]};
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_valid <= 1'b0;
      rd_entry <= '0;
    end else begin
      rd_valid <= rd_req_i;
      if (rd_req_i) begin
        rd_entry <= rd_oob ? '0 : mem[rd_phys];
      end
    end
  end

  assign wrptr_o     = wrptr;
  assign rd_valid_o  = rd_valid;
  assign rd_source_o = rd_entry.source;
  assign rd_target_o = rd_entry.target;
  assign rd_data_o   = rd_entry.data;

endmodule
